// File: rtl/jts16_pkg.sv
// Shared definitions for the jts16 bus arbiters.
// State encoding and requester bounds.
package jts16_pkg;

    localparam int NREQ_MAX = 4;
    localparam int PW       = $clog2(NREQ_MAX);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAITFREE = 3'd2,
        OWN      = 3'd3,
        REL      = 3'd4
    } state_t;

endpackage

// File: rtl/jts16_rr_pick.sv
// Round-robin selector: first set request at or after ptr,
// wrapping modulo NREQ.
module jts16_rr_pick
    import jts16_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        win   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!valid && req[j] && ((int'(ptr) + k) % NREQ == j)) begin
                    valid  = 1'b1;
                    win[j] = 1'b1;
                    idx    = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/jts16_busarb.sv
// 68000 BR/BG/BGACK bus arbiter for external masters.
// Round-robin winner owns the bus until done or hold limit.
module jts16_busarb
    import jts16_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1023,
    parameter int HOLDMAX = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cpu_cen,
    input  logic            ASn,
    input  logic            DTACKn,
    input  logic            BGn,
    output logic            BRn,
    output logic            BGACKn,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            tout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int HW = (HOLDMAX > 0) ? $clog2(HOLDMAX + 1) : 1;
    localparam logic [PW-1:0] LAST    = PW'(NREQ - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HM_LAST = HW'((HOLDMAX > 0) ? HOLDMAX - 1 : 0);

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   widx, widx_n;
    logic [NREQ-1:0] wmask, wmask_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [HW-1:0]   hcnt, hcnt_n;
    logic            relw, relw_n;
    logic            brn_n, bgackn_n, tout_n;
    logic [NREQ-1:0] gnt_n;
    logic [NREQ-1:0] pwin;
    logic [PW-1:0]   pidx;
    logic            pvalid;
    logic [PW-1:0]   nxt_ptr;

    jts16_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .win   (pwin),
        .idx   (pidx),
        .valid (pvalid)
    );

    assign nxt_ptr = (widx == LAST) ? '0 : widx + PW'(1);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            widx   <= '0;
            wmask  <= '0;
            cnt    <= '0;
            hcnt   <= '0;
            relw   <= 1'b0;
            BRn    <= 1'b1;
            BGACKn <= 1'b1;
            gnt    <= '0;
            tout   <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            widx   <= widx_n;
            wmask  <= wmask_n;
            cnt    <= cnt_n;
            hcnt   <= hcnt_n;
            relw   <= relw_n;
            BRn    <= brn_n;
            BGACKn <= bgackn_n;
            gnt    <= gnt_n;
            tout   <= tout_n;
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        widx_n   = widx;
        wmask_n  = wmask;
        cnt_n    = cnt;
        hcnt_n   = hcnt;
        relw_n   = relw;
        brn_n    = BRn;
        bgackn_n = BGACKn;
        gnt_n    = gnt;
        tout_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_cen && pvalid) begin
                    widx_n  = pidx;
                    wmask_n = pwin;
                    brn_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (cpu_cen) begin
                    if (!(|(req & wmask))) begin
                        brn_n   = 1'b1;
                        state_n = IDLE;
                    end else if (!BGn) begin
                        state_n = WAITFREE;
                    end else if (cnt == TO_LAST) begin
                        brn_n   = 1'b1;
                        tout_n  = 1'b1;
                        ptr_n   = nxt_ptr;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            WAITFREE: begin
                // CPU withdrew its grant: fall back, counter is kept
                if (cpu_cen) begin
                    if (BGn) begin
                        state_n = REQ;
                    end else if (ASn && DTACKn) begin
                        bgackn_n = 1'b0;
                        brn_n    = 1'b1;
                        gnt_n    = wmask;
                        hcnt_n   = '0;
                        state_n  = OWN;
                    end
                end
            end
            OWN: begin
                // done is acted on at any clk, not just on cpu_cen
                if (|(done & wmask)) begin
                    gnt_n   = '0;
                    relw_n  = 1'b0;
                    state_n = REL;
                end else if (cpu_cen && HOLDMAX > 0) begin
                    if (hcnt == HM_LAST) begin
                        gnt_n   = '0;
                        tout_n  = 1'b1;
                        relw_n  = 1'b0;
                        state_n = REL;
                    end else begin
                        hcnt_n = hcnt + HW'(1);
                    end
                end
            end
            REL: begin
                if (cpu_cen) begin
                    if (!relw) begin
                        bgackn_n = 1'b1;
                        relw_n   = 1'b1;
                    end else begin
                        ptr_n   = nxt_ptr;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jts16_busarb.sv
// Scoreboard bench for jts16_busarb with a simple 68000 model.
// Grants and timeouts are matched against an expected-event queue.
module tb_jts16_busarb;

    localparam int EV_GNT  = 1;
    localparam int EV_TOUT = 2;

    typedef struct {
        int         kind;
        logic [1:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_cen = 1'b0;
    logic       ASn = 1'b1;
    logic       DTACKn = 1'b1;
    logic       BGn = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] done = 2'b00;
    logic       BRn, BGACKn, busy, tout;
    logic [1:0] gnt;

    ev_t        exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    bit         cpu_dead = 1'b0;
    int         brt = 0;
    logic [1:0] prev_gnt = 2'b00;

    jts16_busarb #(.NREQ(2), .TIMEOUT(8), .HOLDMAX(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cpu_cen (cpu_cen),
        .ASn     (ASn),
        .DTACKn  (DTACKn),
        .BGn     (BGn),
        .BRn     (BRn),
        .BGACKn  (BGACKn),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .busy    (busy),
        .tout    (tout)
    );

    initial forever #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 cpu_cen = 1'b1;
            @(posedge clk);
            #1 cpu_cen = 1'b0;
        end
    end

    // 68000 model: grants two ticks after BRn falls, drops BG on BGACK
    initial begin
        forever begin
            @(posedge clk);
            if (cpu_cen) begin
                #2;
                if (!BGACKn) begin
                    BGn = 1'b1;
                    brt = 0;
                end else if (BRn) begin
                    brt = 0;
                end else if (!cpu_dead) begin
                    brt++;
                    if (brt >= 2) BGn = 1'b0;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait expired", nm);
    endtask

    task automatic push(input int kind, input logic [1:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input logic [1:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got event %0d/%0h expected none",
                     kind, val);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", kind, e.kind);
            check("sb_val", val, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (gnt != 2'b00 && prev_gnt == 2'b00) got(EV_GNT, gnt);
        if (tout) got(EV_TOUT, 2'b00);
        prev_gnt <= gnt;
        check("gnt_onehot", 32'($onehot0(gnt)), 1);
        check("gnt_needs_bgack", 32'(gnt != 0 && BGACKn), 0);
    end

    task automatic tick();
        do @(posedge clk); while (!cpu_cen);
        #1;
    endtask

    task automatic wait_gnt(input string nm);
        int n = 0;
        while (gnt == 2'b00 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (gnt == 2'b00) bound_fail(nm);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) bound_fail(nm);
    endtask

    task automatic pulse_done(input int i);
        @(negedge clk);
        done[i] = 1'b1;
        @(negedge clk);
        done = 2'b00;
        check("gnt_drop_on_done", gnt, 0);
    endtask

    initial begin
        int n;
        int idx;

        repeat (3) @(negedge clk);
        check("rst_brn", BRn, 1);
        check("rst_bgackn", BGACKn, 1);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_tout", tout, 0);
        rst_n = 1'b1;

        // single master
        @(negedge clk);
        push(EV_GNT, 2'b01);
        req = 2'b01;
        tick();
        check("brn_after_req", BRn, 0);
        wait_gnt("single_gnt");
        req = 2'b00;
        tick();
        tick();
        check("single_bgackn", BGACKn, 0);
        check("single_gnt_held", gnt, 2'b01);
        pulse_done(0);
        tick();
        check("single_bgack_rel", BGACKn, 1);
        wait_idle("single_idle");

        // round robin from ptr=1
        push(EV_GNT, 2'b10);
        push(EV_GNT, 2'b01);
        push(EV_GNT, 2'b10);
        push(EV_GNT, 2'b01);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt("rr_gnt");
            idx = gnt[1] ? 1 : 0;
            if (k == 3) req = 2'b00;
            tick();
            tick();
            pulse_done(idx);
            tick();
            tick();
            check("rr_cpu_slot", {BRn, BGACKn}, 2'b11);
        end
        wait_idle("rr_idle");

        // CPU mid-cycle
        ASn = 1'b0;
        push(EV_GNT, 2'b01);
        req = 2'b01;
        n = 0;
        while (BGn && n < 20) begin
            tick();
            n++;
        end
        if (BGn) bound_fail("mid_bg");
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mid_bgackn_held", BGACKn, 1);
            check("mid_gnt_held", gnt, 0);
        end
        ASn = 1'b1;
        tick();
        check("mid_gnt", gnt, 2'b01);
        check("mid_bgackn", BGACKn, 0);
        req = 2'b00;
        pulse_done(0);
        wait_idle("mid_idle");

        // timeout on master 1, then master 0 is preferred
        cpu_dead = 1'b1;
        push(EV_TOUT, 2'b00);
        req = 2'b10;
        tick();
        check("to_brn_low", BRn, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tout && n < 20);
        check("to_ticks", n, 8);
        check("to_brn", BRn, 1);
        check("to_busy", busy, 0);
        req = 2'b11;
        cpu_dead = 1'b0;
        push(EV_GNT, 2'b01);
        wait_gnt("to_next_gnt");
        check("to_next_winner", gnt, 2'b01);
        req = 2'b00;
        pulse_done(0);
        wait_idle("to_idle");

        // hold limit
        push(EV_GNT, 2'b01);
        push(EV_TOUT, 2'b00);
        req = 2'b01;
        wait_gnt("hold_gnt");
        req = 2'b00;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt != 2'b00 && n < 40);
        check("hold_ticks", n, 16);
        check("hold_tout", tout, 1);
        tick();
        check("hold_bgack_rel", BGACKn, 1);
        wait_idle("hold_idle");

        // reset while owning
        push(EV_GNT, 2'b01);
        req = 2'b01;
        wait_gnt("rst_own_gnt");
        req = 2'b00;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_brn", BRn, 1);
        check("arst_bgackn", BGACKn, 1);
        check("arst_gnt", gnt, 0);
        check("arst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(EV_GNT, 2'b10);
        req = 2'b10;
        wait_gnt("post_rst_gnt");
        check("post_rst_winner", gnt, 2'b10);
        req = 2'b00;
        pulse_done(1);
        wait_idle("post_rst_idle");

        repeat (4) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
